shift_unit_seq: RTL and testbench
=================================

# shift_unit_seq

Parametrised sequential shifter, successor to the combinational one-bit left shifter. It accepts a W-bit operand, a shift amount and a mode, then shifts one bit position per clock until the amount is exhausted. It reports the result and the last bit shifted out through a start/ready/done handshake. It sits in the datapath next to the ALU and serves multi-bit shift instructions.

## Interface
- W, default 8: operand width, must be ≥ 2.
- AW, default $clog2(W): shift-amount width; legal amounts are 0..W-1.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- start  in  1  request; sampled only while ready=1.
- mode  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- shift_amt  in  AW  number of one-bit steps.
- data_to_shift  in  W  operand.
- ready  out  1  unit idle, can accept start.
- done  out  1  one-cycle pulse: result valid.
- shifted_data  out  W  result register.
- carry_out  out  1  last bit shifted or rotated out.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE (ready=1):
  - On start=1: capture data_to_shift into shifted_data, latch mode, load the counter with shift_amt, clear carry_out.
  - Next state is SHIFT if shift_amt≠0, otherwise DONE.
- SHIFT:
  - Each edge applies one step to shifted_data, updates carry_out and decrements the counter.
  - Moves to DONE on the edge where the counter reaches 0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Step rules per mode:
  - SLL: shift left, fill 0, carry_out = old MSB.
  - SRL: shift right, fill 0, carry_out = old LSB.
  - SRA: shift right, fill with old MSB, carry_out = old LSB.
  - ROL: rotate left, carry_out = old MSB.
- ready = (state==IDLE).
- start while ready=0 is ignored, not queued.
- Inputs are sampled only on the accepting edge; later changes to them have no effect on the running shift.
- shifted_data and carry_out hold their values from DONE until the next accepted start.

## Timing
- Reset values: ready=1, done=0, shifted_data=0, carry_out=0, state IDLE, counter 0.
- rst_n low mid-operation aborts the shift. On the next edge all outputs take their reset values and no done pulse is produced.
- Start accepted at edge k with amount N: the shifts occur on edges k+1..k+N, and done is high in the cycle following edge k+N.
  - N=0: done is high in the cycle after edge k, with data unchanged and carry_out=0.
- ready is low from edge k until done deasserts. ready rises in the cycle after done, so back-to-back requests have a gap of at least one cycle.
- rst_n low has priority over start on the same edge.

## Configuration
- SHIFT_ROTATE_EN defined: mode 11 performs ROL as specified above.
- SHIFT_ROTATE_EN undefined: the rotate path is not compiled, and mode 11 behaves exactly as SLL (fill 0, carry_out = old MSB).

## Structure
- shift_pkg holds:
  - mode encodings MODE_SLL, MODE_SRL, MODE_SRA, MODE_ROL;
  - FSM state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One combinational sub-module, shift_step. Inputs: W-bit value and mode. Outputs: next value and the bit shifted out. It is instantiated once inside the SHIFT datapath.
- The FSM, counter and result registers live in shift_unit_seq.

## Test plan (W=8)
- SLL 8'b01110101 by 3 → done after 3 shift edges; shifted_data=8'b10101000, carry_out=1.
- SRA 8'b10000000 by 7 → shifted_data=8'b11111111, carry_out=0.
- SRL 8'b11110010 by 1 → shifted_data=8'b01111001, carry_out=0.
- ROL 8'b11110010 by 4:
  - with SHIFT_ROTATE_EN → 8'b00101111, carry_out=1;
  - without it → 8'b00100000, carry_out=1.
- Amount 0 on 8'b11111111 → done in the cycle after the accepting edge; shifted_data=8'b11111111, carry_out=0.
- start pulsed while busy, then rst_n low mid-shift:
  - the busy start is ignored;
  - after the reset edge: ready=1, done=0, shifted_data=0, and no done pulse follows.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter (rotate gated by SHIFT_ROTATE_EN).
// Latency: n/a, types and constants only.
// Backpressure: n/a.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_unit_seq_if.sv
// Request/result bundle between a shift requester (master) and the shifter (slave).
// Latency: n/a, wiring only.
// Backpressure: master may only start while ready is high; starts while busy are dropped.
interface shift_unit_seq_if
  import shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = $clog2(W)
);
  logic          start;
  mode_t         mode;
  logic [AW-1:0] shift_amt;
  logic [W-1:0]  data_to_shift;
  logic          ready;
  logic          done;
  logic [W-1:0]  shifted_data;
  logic          carry_out;

  modport master (
    output start, mode, shift_amt, data_to_shift,
    input  ready, done, shifted_data, carry_out
  );

  modport slave (
    input  start, mode, shift_amt, data_to_shift,
    output ready, done, shifted_data, carry_out
  );
endinterface

// File: rtl/shift_step.sv
// One-bit shift/rotate step; mode 11 rotates only with SHIFT_ROTATE_EN, else acts as SLL.
// Latency: combinational.
// Backpressure: none.
module shift_step
  import shift_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  input  mode_t        mode,
  output logic [W-1:0] nxt,
  output logic         bit_out
);

  always_comb begin
    nxt     = {val[W-2:0], 1'b0};
    bit_out = val[W-1];
    case (mode)
      MODE_SRL: begin
        nxt     = {1'b0, val[W-1:1]};
        bit_out = val[0];
      end
      MODE_SRA: begin
        nxt     = {val[W-1], val[W-1:1]};
        bit_out = val[0];
      end
`ifdef SHIFT_ROTATE_EN
      MODE_ROL: begin
        nxt     = {val[W-2:0], val[W-1]};
        bit_out = val[W-1];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Sequential shifter, one bit per clock; rotate mode compiled in only with SHIFT_ROTATE_EN.
// Latency: N shift edges after the accepting edge, then a one-cycle done pulse.
// Backpressure: ready low from acceptance until done drops; starts while busy are ignored.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int W  = 8,
  parameter int AW = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_unit_seq_if.slave  bus
);

  state_t        state_q, state_d;
  mode_t         mode_q;
  logic [AW-1:0] cnt_q;
  logic [W-1:0]  data_q;
  logic          carry_q;
  logic [W-1:0]  step_val;
  logic          step_bit;
  logic          accept;

  shift_step #(.W(W)) u_step (
    .val     (data_q),
    .mode    (mode_q),
    .nxt     (step_val),
    .bit_out (step_bit)
  );

  assign accept = (state_q == ST_IDLE) && bus.start;

  always_comb begin
    state_d   = state_q;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) state_d = (bus.shift_amt != '0) ? ST_SHIFT : ST_DONE;
      end
      // Leave on the edge that takes the counter from 1 to 0.
      ST_SHIFT: if (cnt_q == AW'(1)) state_d = ST_DONE;
      ST_DONE: begin
        bus.done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SLL;
      cnt_q   <= '0;
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q  <= bus.data_to_shift;
        mode_q  <= bus.mode;
        cnt_q   <= bus.shift_amt;
        carry_q <= 1'b0;
      end else if (state_q == ST_SHIFT) begin
        data_q  <= step_val;
        carry_q <= step_bit;
        cnt_q   <= cnt_q - AW'(1);
      end
    end
  end

  assign bus.shifted_data = data_q;
  assign bus.carry_out    = carry_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Directed bench for shift_unit_seq (W=8); expected rotate results follow SHIFT_ROTATE_EN.
// Drives and samples on the falling edge.
module tb_shift_unit_seq;
  import shift_pkg::*;

  localparam int W  = 8;
  localparam int AW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  shift_unit_seq_if #(.W(W), .AW(AW)) bus ();

  shift_unit_seq #(.W(W), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input mode_t m, input logic [AW-1:0] n,
                     input logic [W-1:0] d, input logic [W-1:0] exp_d, input logic exp_c);
    int c;
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.shift_amt = n; bus.data_to_shift = d;
    @(negedge clk);
    // Scramble inputs after acceptance; the running shift must not see them.
    bus.start = 1'b0; bus.mode = mode_t'(~m); bus.shift_amt = ~n; bus.data_to_shift = ~d;
    chk({tag, "_busy"}, 32'(bus.ready), 32'(0));
    c = 0;
    while (bus.done !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(n));
    chk({tag, "_data"}, 32'(bus.shifted_data), 32'(exp_d));
    chk({tag, "_carry"}, 32'(bus.carry_out), 32'(exp_c));
    @(negedge clk);
    chk({tag, "_rdy_after"}, 32'({bus.ready, bus.done}), 32'(2'b10));
    chk({tag, "_hold"}, 32'({bus.carry_out, bus.shifted_data}), 32'({exp_c, exp_d}));
  endtask

  initial begin
    int seen;
    bus.start = 1'b0; bus.mode = MODE_SLL; bus.shift_amt = '0; bus.data_to_shift = '0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'({bus.ready, bus.done, bus.carry_out, bus.shifted_data}),
        32'({1'b1, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;

    run("sll3", MODE_SLL, 3'd3, 8'b01110101, 8'b10101000, 1'b1);
    run("sra7", MODE_SRA, 3'd7, 8'b10000000, 8'b11111111, 1'b0);
    run("srl1", MODE_SRL, 3'd1, 8'b11110010, 8'b01111001, 1'b0);
`ifdef SHIFT_ROTATE_EN
    run("rol4", MODE_ROL, 3'd4, 8'b11110010, 8'b00101111, 1'b1);
`else
    run("rol4", MODE_ROL, 3'd4, 8'b11110010, 8'b00100000, 1'b1);
`endif
    run("amt0", MODE_SLL, 3'd0, 8'b11111111, 8'b11111111, 1'b0);
    run("sra_pos", MODE_SRA, 3'd2, 8'b01000001, 8'b00010000, 1'b0);

    // Busy start ignored, then reset mid-shift.
    @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_SLL; bus.shift_amt = 3'd5; bus.data_to_shift = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("mid_data1", 32'(bus.shifted_data), 32'(8'hFE));
    bus.start = 1'b1; bus.mode = MODE_SRL; bus.shift_amt = 3'd0; bus.data_to_shift = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_start_ign", 32'({bus.ready, bus.shifted_data}), 32'({1'b0, 8'hFC}));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_state", 32'({bus.ready, bus.done, bus.carry_out, bus.shifted_data}),
        32'({1'b1, 1'b0, 1'b0, 8'h00}));
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    chk("no_done_after_abort", 32'(seen), 32'(0));

    // Reset has priority over a simultaneous start.
    bus.start = 1'b1; bus.data_to_shift = 8'hA5; bus.shift_amt = 3'd1; rst_n = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; rst_n = 1'b1;
    chk("rst_over_start", 32'({bus.ready, bus.shifted_data}), 32'({1'b1, 8'h00}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
